// File: rtl/spi_master_mc.sv
// spi_master_mc: SPI master with run-time CPOL/CPHA, bit order and SCLK divider.
//   Word stream in (tx_*_i valid/ready), one received word out per frame
//   (rx_*_o), NUM_CS one-hot active-low chip selects, burst frames with CS held.
// Ports:
//   clk_i, rst_i         clock, synchronous active-high reset
//   cfg_*_i              frame configuration, latched when a word is accepted in IDLE
//   tx_data_i/tx_cont_i  word to send / keep CS low after this frame
//   tx_valid_i/tx_ready_o  word handshake (ready only in IDLE and GAP)
//   cs_release_i         ends a held burst
//   rx_data_o/rx_valid_o received word and its one-cycle strobe
//   busy_o               high whenever the engine is not idle
//   sclk_o, mosi_o, cs_n_o, miso_i  SPI pins
// Optional feature: define SPI_MST_LOOPBACK_EN to add cfg_loopback_i; when it is
//   latched high the receiver samples the internal mosi instead of miso_i.
`timescale 1ns/1ps

module spi_master_mc #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned NUM_CS   = 4,
  parameter int unsigned DIV_W    = 8,
  parameter logic        CPOL_RST = 1'b1
) (
  input  logic                                           clk_i,
  input  logic                                           rst_i,
  input  logic                                           cfg_cpol_i,
  input  logic                                           cfg_cpha_i,
  input  logic                                           cfg_lsb_first_i,
  input  logic [DIV_W-1:0]                               cfg_div_i,
  input  logic [((NUM_CS > 1) ? $clog2(NUM_CS) : 1)-1:0] cfg_cs_sel_i,
`ifdef SPI_MST_LOOPBACK_EN
  input  logic                                           cfg_loopback_i,
`endif
  input  logic [DATA_W-1:0]                              tx_data_i,
  input  logic                                           tx_cont_i,
  input  logic                                           tx_valid_i,
  output logic                                           tx_ready_o,
  input  logic                                           cs_release_i,
  output logic [DATA_W-1:0]                              rx_data_o,
  output logic                                           rx_valid_o,
  output logic                                           busy_o,
  output logic                                           sclk_o,
  output logic                                           mosi_o,
  output logic [NUM_CS-1:0]                              cs_n_o,
  input  logic                                           miso_i
);

  localparam int unsigned CSW   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;
  localparam int unsigned NEDGE = 2 * DATA_W;
  localparam int unsigned EW    = $clog2(NEDGE + 1);
  localparam int unsigned BW    = $clog2(DATA_W);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LEAD  = 3'd1;
  localparam logic [2:0] S_XFER  = 3'd2;
  localparam logic [2:0] S_TRAIL = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;

  // Chip-select decode; an out-of-range index leaves every select inactive.
  function automatic logic [NUM_CS-1:0] cs_decode(input logic [CSW-1:0] sel);
    logic [NUM_CS-1:0] r;
    r = '1;
    for (int unsigned i = 0; i < NUM_CS; i++) begin
      if (sel == CSW'(i)) r[i] = 1'b0;
    end
    return r;
  endfunction

  logic [2:0]        state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic              cpol_q, cpol_d;
  logic              cpha_q, cpha_d;
  logic              lsb_q, lsb_d;
  logic              cont_q, cont_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic [EW-1:0]     edge_q, edge_d;
  logic              sclk_q, sclk_d;
  logic              mosi_q, mosi_d;
  logic [NUM_CS-1:0] cs_n_q, cs_n_d;
  logic              tx_ready_q, tx_ready_d;
  logic              rx_valid_q, rx_valid_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              busy_q, busy_d;
`ifdef SPI_MST_LOOPBACK_EN
  logic              lb_q, lb_d;
`endif

  logic          hp_end;
  logic          accept;
  logic          lead_edge;
  logic          samp_now;
  logic          shift_now;
  logic [BW-1:0] samp_idx;
  logic [BW-1:0] shift_idx;
  logic [BW-1:0] rx_pos;
  logic [BW-1:0] tx_pos;
  logic          din;
  logic          first_bit_idle;
  logic          first_bit_gap;

  // Half-period timing and the handshake.
  assign hp_end = (cnt_q == div_q);
  assign accept = tx_valid_i & tx_ready_q;

  // edge_q counts edges already issued, so the coming edge k = edge_q+1 is a
  // leading edge when edge_q is even.
  assign lead_edge = ~edge_q[0];
  assign samp_now  = cpha_q ? ~lead_edge : lead_edge;
  assign shift_now = cpha_q ? lead_edge
                            : (~lead_edge && (edge_q != EW'(NEDGE - 1)));

  // Both modes sample bit floor(edge_q/2); the bit shifted out on the coming
  // edge is (k-1)/2 for CPHA=1 and k/2 for CPHA=0.
  assign samp_idx  = BW'(edge_q >> 1);
  assign shift_idx = cpha_q ? BW'(edge_q >> 1) : BW'((edge_q + EW'(1)) >> 1);
  assign rx_pos    = lsb_q ? samp_idx  : BW'(DATA_W - 1) - samp_idx;
  assign tx_pos    = lsb_q ? shift_idx : BW'(DATA_W - 1) - shift_idx;

  assign first_bit_idle = cfg_lsb_first_i ? tx_data_i[0] : tx_data_i[DATA_W-1];
  assign first_bit_gap  = lsb_q           ? tx_data_i[0] : tx_data_i[DATA_W-1];

`ifdef SPI_MST_LOOPBACK_EN
  assign din = lb_q ? mosi_q : miso_i;
`else
  assign din = miso_i;
`endif

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      div_q      <= '0;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      lsb_q      <= 1'b0;
      cont_q     <= 1'b0;
      tx_q       <= '0;
      rx_sh_q    <= '0;
      cnt_q      <= '0;
      edge_q     <= '0;
      sclk_q     <= CPOL_RST;
      mosi_q     <= 1'b0;
      cs_n_q     <= '1;
      tx_ready_q <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
      busy_q     <= 1'b0;
`ifdef SPI_MST_LOOPBACK_EN
      lb_q       <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      cpol_q     <= cpol_d;
      cpha_q     <= cpha_d;
      lsb_q      <= lsb_d;
      cont_q     <= cont_d;
      tx_q       <= tx_d;
      rx_sh_q    <= rx_sh_d;
      cnt_q      <= cnt_d;
      edge_q     <= edge_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      cs_n_q     <= cs_n_d;
      tx_ready_q <= tx_ready_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
      busy_q     <= busy_d;
`ifdef SPI_MST_LOOPBACK_EN
      lb_q       <= lb_d;
`endif
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    cpol_d     = cpol_q;
    cpha_d     = cpha_q;
    lsb_d      = lsb_q;
    cont_d     = cont_q;
    tx_d       = tx_q;
    rx_sh_d    = rx_sh_q;
    cnt_d      = cnt_q;
    edge_d     = edge_q;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    cs_n_d     = cs_n_q;
    rx_valid_d = 1'b0;
    rx_data_d  = rx_data_q;
`ifdef SPI_MST_LOOPBACK_EN
    lb_d       = lb_q;
`endif

    case (state_q)
      S_IDLE: begin
        sclk_d = cfg_cpol_i;
        if (accept) begin
          cpol_d  = cfg_cpol_i;
          cpha_d  = cfg_cpha_i;
          lsb_d   = cfg_lsb_first_i;
          div_d   = cfg_div_i;
          tx_d    = tx_data_i;
          cont_d  = tx_cont_i;
          cs_n_d  = cs_decode(cfg_cs_sel_i);
          cnt_d   = '0;
          edge_d  = '0;
          rx_sh_d = '0;
`ifdef SPI_MST_LOOPBACK_EN
          lb_d    = cfg_loopback_i;
`endif
          if (!cfg_cpha_i) mosi_d = first_bit_idle;
          state_d = S_LEAD;
        end
      end

      S_LEAD: begin
        if (hp_end) begin
          cnt_d   = '0;
          state_d = S_XFER;
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end

      S_XFER: begin
        if (hp_end) begin
          cnt_d  = '0;
          sclk_d = ~sclk_q;
          edge_d = edge_q + EW'(1);
          if (samp_now)  rx_sh_d[rx_pos] = din;
          if (shift_now) mosi_d = tx_q[tx_pos];
          if (edge_q == EW'(NEDGE - 1)) state_d = S_TRAIL;
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end

      S_TRAIL: begin
        if (hp_end) begin
          cnt_d      = '0;
          rx_valid_d = 1'b1;
          rx_data_d  = rx_sh_q;
          if (cont_q) begin
            state_d = S_GAP;
          end else begin
            cs_n_d  = '1;
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end

      S_GAP: begin
        // A new word wins over a simultaneous release; config and CS persist.
        if (accept) begin
          tx_d    = tx_data_i;
          cont_d  = tx_cont_i;
          cnt_d   = '0;
          edge_d  = '0;
          rx_sh_d = '0;
          if (!cpha_q) mosi_d = first_bit_gap;
          state_d = S_LEAD;
        end else if (cs_release_i) begin
          cs_n_d  = '1;
          state_d = S_IDLE;
        end
      end

      default: begin
        cs_n_d  = '1;
        state_d = S_IDLE;
      end
    endcase

    busy_d     = (state_d != S_IDLE);
    tx_ready_d = (state_d == S_IDLE) || (state_d == S_GAP);
  end

  assign tx_ready_o = tx_ready_q;
  assign rx_data_o  = rx_data_q;
  assign rx_valid_o = rx_valid_q;
  assign busy_o     = busy_q;
  assign sclk_o     = sclk_q;
  assign mosi_o     = mosi_q;
  assign cs_n_o     = cs_n_q;

endmodule

// File: tb/tb_spi_master_mc.sv
// Self-checking bench for spi_master_mc: directed scenarios plus randomized
// frames against a behavioural SPI slave and a word-level frame model.
`timescale 1ns/1ps

module tb_spi_master_mc;

  logic       clk;
  logic       rst;
  logic       cfg_cpol, cfg_cpha, cfg_lsb;
  logic [7:0] cfg_div;
  logic [1:0] cfg_cs_sel;
  logic [7:0] tx_data;
  logic       tx_cont, tx_valid, cs_release;
  logic       miso;
`ifdef SPI_MST_LOOPBACK_EN
  logic       cfg_loopback;
`endif

  logic       tx_ready, rx_valid, busy, sclk, mosi;
  logic [7:0] rx_data;
  logic [3:0] cs_n;
  logic       tx_ready3, rx_valid3, busy3, sclk3, mosi3;
  logic [7:0] rx_data3;
  logic [2:0] cs_n3;

  spi_master_mc #(.DATA_W(8), .NUM_CS(4), .DIV_W(8), .CPOL_RST(1'b1)) u_dut (
    .clk_i(clk), .rst_i(rst),
    .cfg_cpol_i(cfg_cpol), .cfg_cpha_i(cfg_cpha), .cfg_lsb_first_i(cfg_lsb),
    .cfg_div_i(cfg_div), .cfg_cs_sel_i(cfg_cs_sel),
`ifdef SPI_MST_LOOPBACK_EN
    .cfg_loopback_i(cfg_loopback),
`endif
    .tx_data_i(tx_data), .tx_cont_i(tx_cont), .tx_valid_i(tx_valid),
    .tx_ready_o(tx_ready), .cs_release_i(cs_release),
    .rx_data_o(rx_data), .rx_valid_o(rx_valid), .busy_o(busy),
    .sclk_o(sclk), .mosi_o(mosi), .cs_n_o(cs_n), .miso_i(miso)
  );

  // Second instance with three selects: index 3 is out of range there.
  spi_master_mc #(.DATA_W(8), .NUM_CS(3), .DIV_W(8), .CPOL_RST(1'b1)) u_dut3 (
    .clk_i(clk), .rst_i(rst),
    .cfg_cpol_i(cfg_cpol), .cfg_cpha_i(cfg_cpha), .cfg_lsb_first_i(cfg_lsb),
    .cfg_div_i(cfg_div), .cfg_cs_sel_i(cfg_cs_sel),
`ifdef SPI_MST_LOOPBACK_EN
    .cfg_loopback_i(cfg_loopback),
`endif
    .tx_data_i(tx_data), .tx_cont_i(tx_cont), .tx_valid_i(tx_valid),
    .tx_ready_o(tx_ready3), .cs_release_i(cs_release),
    .rx_data_o(rx_data3), .rx_valid_o(rx_valid3), .busy_o(busy3),
    .sclk_o(sclk3), .mosi_o(mosi3), .cs_n_o(cs_n3), .miso_i(miso)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;

  // Latched frame configuration as the model sees it.
  logic       m_cpol, m_cpha, m_lsb, m_lb;
  logic [7:0] m_div;
  logic [1:0] m_sel;
  logic       in_gap;

  // Behavioural slave: counts leading/trailing SCLK edges, presents its word.
  logic       slv_en;
  logic       miso_fix;
  logic [7:0] s_word;
  int lead_cnt = 0, trail_cnt = 0, lead_base = 0, trail_base = 0;
  int mon_cnt = 0, mon_base = 0;
  int s_idx;
  logic mon_log [0:255];

  function automatic logic word_bit(input logic [7:0] w, input int i, input logic lsb);
    logic [7:0] t;
    t = lsb ? (w >> i) : (w >> (7 - i));
    return t[0];
  endfunction

  always @(sclk) begin
    if (sclk !== m_cpol) begin
      lead_cnt = lead_cnt + 1;
      if (!m_cpha) begin mon_log[mon_cnt % 256] = mosi; mon_cnt = mon_cnt + 1; end
    end else begin
      trail_cnt = trail_cnt + 1;
      if (m_cpha) begin mon_log[mon_cnt % 256] = mosi; mon_cnt = mon_cnt + 1; end
    end
  end

  always_comb begin
    s_idx = m_cpha ? (lead_cnt - lead_base - 1) : (trail_cnt - trail_base);
    if (!slv_en)                   miso = miso_fix;
    else if (s_idx >= 0 && s_idx < 8) miso = word_bit(s_word, s_idx, m_lsb);
    else                           miso = 1'b0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_cfg(input logic cpol, input logic cpha, input logic lsb,
                           input logic [7:0] div, input logic [1:0] sel, input logic lb);
    cfg_cpol = cpol; cfg_cpha = cpha; cfg_lsb = lsb; cfg_div = div; cfg_cs_sel = sel;
`ifdef SPI_MST_LOOPBACK_EN
    cfg_loopback = lb;
`else
    if (lb) ;
`endif
  endtask

  // One frame, called at a negedge; returns at the negedge after the rx pulse.
  task automatic frame(input logic [7:0] d, input logic cont,
                       input logic cpol, input logic cpha, input logic lsb,
                       input logic [7:0] div, input logic [1:0] sel,
                       input logic use_slv, input logic [7:0] sw,
                       input logic lb, input logic rel);
    int n, lat, cs_bad;
    logic [3:0] exp_cs;
    logic [2:0] exp_cs3;
    logic [7:0] exp_rx, obs_w;
    bit got;
    if (!in_gap) begin
      m_cpol = cpol; m_cpha = cpha; m_lsb = lsb; m_div = div; m_sel = sel; m_lb = lb;
      drive_cfg(cpol, cpha, lsb, div, sel, lb);
      @(negedge clk);
    end else begin
      chk("gap_busy", busy, 1);
      chk("gap_sclk", sclk, m_cpol);
      drive_cfg(1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom), 2'($urandom), 1'($urandom));
    end
    exp_cs  = ~(4'b0001 << m_sel);
    exp_cs3 = (m_sel < 2'd3) ? ~(3'b001 << m_sel) : 3'b111;
    exp_rx  = use_slv ? sw : (m_lb ? d : {8{miso_fix}});
    lat     = 18 * (int'(m_div) + 1);

    s_word = sw; slv_en = use_slv;
    lead_base = lead_cnt; trail_base = trail_cnt; mon_base = mon_cnt;
    tx_data = d; tx_cont = cont; tx_valid = 1'b1; cs_release = rel;
    n = 0;
    while (!tx_ready && n < 50) begin @(negedge clk); n++; end
    chk("ready_before_accept", tx_ready, 1);
    @(posedge clk);
    @(negedge clk);
    tx_valid = 1'b0; cs_release = 1'b0; tx_data = 8'($urandom);
    drive_cfg(1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom), 2'($urandom), 1'($urandom));

    chk("lead_cs_n", cs_n, exp_cs);
    chk("lead_sclk", sclk, m_cpol);
    chk("lead_busy", busy, 1);
    chk("lead_ready", tx_ready, 0);

    n = 0; got = 0; cs_bad = 0;
    while (!got && n < lat + 20) begin
      if (rx_valid) got = 1;
      else begin
        if (cs_n !== exp_cs) cs_bad++;
        if (n == 17 * (int'(m_div) + 1)) chk("trail_sclk", sclk, m_cpol);
        @(negedge clk);
        n++;
      end
    end
    chk("latency", n, lat);
    chk("rx_data", rx_data, exp_rx);
    chk("cs_hold", cs_bad, 0);
    chk("cs_end", cs_n, cont ? exp_cs : 4'hF);
    chk("u3_rx_valid", rx_valid3, 1);
    chk("u3_rx_data", rx_data3, exp_rx);
    chk("u3_cs_end", cs_n3, cont ? exp_cs3 : 3'b111);

    obs_w = '0;
    for (int i = 0; i < 8; i++) obs_w[m_lsb ? i : 7 - i] = mon_log[(mon_base + i) % 256];
    chk("mosi_bits", obs_w, d);
    chk("mosi_edges", mon_cnt - mon_base, 8);

    @(negedge clk);
    chk("rx_pulse_width", rx_valid, 0);
    chk("post_busy", busy, cont);
    chk("u3_post_busy", busy3, cont);
    in_gap = cont;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int pulses;
    rst = 1'b1; tx_valid = 1'b0; tx_cont = 1'b0; tx_data = '0; cs_release = 1'b0;
    drive_cfg(1'b0, 1'b0, 1'b0, 8'd0, 2'd0, 1'b0);
    slv_en = 1'b0; miso_fix = 1'b0; s_word = '0; in_gap = 1'b0;
    m_cpol = 1'b0; m_cpha = 1'b0; m_lsb = 1'b0; m_lb = 1'b0; m_div = '0; m_sel = '0;

    // Reset values.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cs_n", cs_n, 4'hF);
    chk("rst_sclk", sclk, 1);
    chk("rst_mosi", mosi, 0);
    chk("rst_ready", tx_ready, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_ready", tx_ready, 1);
    chk("idle_sclk_tracks_cpol", sclk, 0);

    // Mode 3, MSB first, H=2, miso tied high.
    miso_fix = 1'b1;
    frame(8'h5A, 0, 1, 1, 0, 8'd1, 2'd0, 0, 8'h00, 0, 0);
    miso_fix = 1'b0;

    // All four modes in both bit orders against a slave echoing 0xC3.
    for (int m = 0; m < 8; m++)
      frame(8'($urandom), 0, 1'(m >> 1), 1'(m), 1'(m >> 2), 8'd1, 2'd0, 1, 8'hC3, 0, 0);

    // Burst on select 2.
    frame(8'h11, 1, 0, 0, 0, 8'd1, 2'd2, 1, 8'h3C, 0, 0);
    frame(8'h22, 0, 0, 0, 0, 8'd1, 2'd2, 1, 8'h96, 0, 0);

    // GAP: word and release together start a frame; release alone returns to IDLE.
    frame(8'h81, 1, 1, 0, 1, 8'd0, 2'd1, 1, 8'h7E, 0, 0);
    frame(8'h42, 1, 0, 0, 0, 8'd0, 2'd0, 1, 8'hE1, 0, 1);
    cs_release = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cs_release = 1'b0;
    chk("release_cs_n", cs_n, 4'hF);
    chk("release_busy", busy, 0);
    in_gap = 1'b0;

    // Reset in the middle of the transfer (just before edge 5 with H=2).
    drive_cfg(1'b0, 1'b0, 1'b0, 8'd1, 2'd1, 1'b0);
    m_cpol = 1'b0; m_cpha = 1'b0;
    @(negedge clk);
    tx_data = 8'hF0; tx_cont = 1'b0; tx_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (11) @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_cs_n", cs_n, 4'hF);
    chk("midrst_sclk", sclk, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_rx_valid", rx_valid, 0);
    chk("midrst_ready", tx_ready, 0);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (rx_valid) pulses++;
    end
    chk("midrst_no_rx", pulses, 0);

    // Out-of-range select on the three-select instance.
    frame(8'h5C, 0, 0, 1, 1, 8'd1, 2'd3, 0, 8'h00, 0, 0);

`ifdef SPI_MST_LOOPBACK_EN
    miso_fix = 1'b0;
    frame(8'hA5, 0, 0, 0, 0, 8'd1, 2'd3, 0, 8'h00, 1, 0);
    frame(8'h3B, 0, 1, 1, 1, 8'd2, 2'd0, 0, 8'h00, 1, 0);
`endif

    // Randomized frames, bursts included.
    for (int r = 0; r < 12; r++)
      frame(8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            8'($urandom_range(0, 3)), 2'($urandom), 1, 8'($urandom), 0, 1'($urandom));
    if (in_gap) begin
      cs_release = 1'b1;
      @(posedge clk);
      @(negedge clk);
      cs_release = 1'b0;
      chk("final_release_cs_n", cs_n, 4'hF);
      in_gap = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
